// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache (1 or 2 ways) with a
// single outstanding refill to the memory controller.
module icache_assoc #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 7,
  parameter int ADDR_W   = 18
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              IF_in,
  input  logic [ADDR_W-1:0] IFAddr_in,
  input  logic              flush_in,
  input  logic              MEM_MCAccess_in,
  input  logic              MC_busyMEM_in,
  input  logic              MCinstE_in,
  input  logic [31:0]       MCinst_in,
  output logic              IF_instE_out,
  output logic [31:0]       IF_inst_out,
  output logic              MCE_out,
  output logic [31:0]       MC_addr_out,
  output logic [15:0]       miss_cnt_out,
  output logic [1:0]        fsm_state
);

  localparam int SETS   = 1 << SET_BITS;
  localparam int TAG_W  = ADDR_W - 2 - SET_BITS;
  localparam int WORD_W = ADDR_W - 2;

  // Refill handshake: once MCE_out rises it stays high with MC_addr_out
  // constant until the cycle MCinstE_in is seen (a one-cycle data pulse);
  // MCinstE_in is only accepted while in WAIT and ignored everywhere else.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t            state;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   lru_q;            // per set: way to replace next
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS];
  logic [WORD_W-1:0] req_q;            // latched word address of the miss
  logic              flushed_q;        // flush seen during this WAIT
  logic              drop_q;           // fetch abandoned during this WAIT

  logic [SET_BITS-1:0] fetch_set;
  logic [TAG_W-1:0]    fetch_tag;
  logic [SET_BITS-1:0] req_set;
  logic [TAG_W-1:0]    req_tag;
  logic                fetch_unused;

  assign fetch_set    = IFAddr_in[SET_BITS+1:2];
  assign fetch_tag    = IFAddr_in[ADDR_W-1:SET_BITS+2];
  assign req_set      = req_q[SET_BITS-1:0];
  assign req_tag      = req_q[WORD_W-1:SET_BITS];
  // Byte offset inside the word plays no part in an instruction fetch.
  assign fetch_unused = ^IFAddr_in[1:0];
  assign fsm_state    = state;

  logic        hit;
  logic        hit_way;
  logic [31:0] hit_data;
  logic        victim;
  logic        found_free;

  // Parallel tag compare across all valid ways of the indexed set.
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][fetch_set] && (tag_q[w][fetch_set] == fetch_tag)) begin
        hit      = 1'b1;
        hit_way  = w[0];
        hit_data = data_q[w][fetch_set];
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the LRU-indicated way.
  always_comb begin
    victim     = (WAYS > 1) ? lru_q[req_set] : 1'b0;
    found_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !valid_q[w][req_set]) begin
        victim     = w[0];
        found_free = 1'b1;
      end
    end
  end

  // Controller FSM, cache arrays and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      lru_q        <= '0;
      req_q        <= '0;
      flushed_q    <= 1'b0;
      drop_q       <= 1'b0;
      IF_instE_out <= 1'b0;
      IF_inst_out  <= '0;
      MCE_out      <= 1'b0;
      MC_addr_out  <= '0;
      miss_cnt_out <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          data_q[w][s] <= '0;
        end
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        lru_q <= '0;
      end
      case (state)
        IDLE: begin
          if (IF_in) begin
            if (hit && !flush_in) begin
              IF_instE_out <= 1'b1;
              IF_inst_out  <= hit_data;
              if (WAYS > 1) lru_q[fetch_set] <= ~hit_way;
              state <= RESP;
            end else begin
              req_q <= IFAddr_in[ADDR_W-1:2];
              if (miss_cnt_out != 16'hFFFF) miss_cnt_out <= miss_cnt_out + 16'd1;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (!IF_in) begin
            state <= IDLE;
          end else if (!(MEM_MCAccess_in || MC_busyMEM_in)) begin
            MCE_out     <= 1'b1;
            MC_addr_out <= 32'({req_q, 2'b00});
            flushed_q   <= 1'b0;
            drop_q      <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (flush_in) flushed_q <= 1'b1;
          if (!IF_in) drop_q <= 1'b1;
          if (MCinstE_in) begin
            MCE_out     <= 1'b0;
            MC_addr_out <= '0;
            // A flush during this refill makes the word unsafe to keep.
            if (!flush_in && !flushed_q) begin
              valid_q[victim][req_set] <= 1'b1;
              tag_q[victim][req_set]   <= req_tag;
              data_q[victim][req_set]  <= MCinst_in;
              if (WAYS > 1) lru_q[req_set] <= ~victim;
            end
            if (IF_in && !drop_q) begin
              IF_instE_out <= 1'b1;
              IF_inst_out  <= MCinst_in;
              state        <= RESP;
            end else begin
              state <= IDLE;
            end
          end
        end
        RESP: begin
          IF_instE_out <= 1'b0;
          IF_inst_out  <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: vector table, directed corner sequences and a random
// fetch stream checked against a recency-list cache model.
module tb_icache_assoc;

  localparam int WAYS = 2;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        IF_in;
  logic [17:0] IFAddr_in;
  logic        flush_in;
  logic        MEM_MCAccess_in;
  logic        MC_busyMEM_in;
  logic        MCinstE_in;
  logic [31:0] MCinst_in;
  logic        IF_instE_out;
  logic [31:0] IF_inst_out;
  logic        MCE_out;
  logic [31:0] MC_addr_out;
  logic [15:0] miss_cnt_out;
  logic [1:0]  fsm_state;

  icache_assoc #(.WAYS(WAYS), .SET_BITS(7), .ADDR_W(18)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .IF_in(IF_in),
    .IFAddr_in(IFAddr_in), .flush_in(flush_in), .MEM_MCAccess_in(MEM_MCAccess_in),
    .MC_busyMEM_in(MC_busyMEM_in), .MCinstE_in(MCinstE_in), .MCinst_in(MCinst_in),
    .IF_instE_out(IF_instE_out), .IF_inst_out(IF_inst_out), .MCE_out(MCE_out),
    .MC_addr_out(MC_addr_out), .miss_cnt_out(miss_cnt_out), .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state and reference model.
  logic [31:0] exp_q[$];
  logic [15:0] rec [128][$];           // per set: word addresses, LRU first
  logic [31:0] mdata [logic [15:0]];
  logic [15:0] exp_cnt;

  typedef struct {
    logic [17:0] addr;
    logic [31:0] word;
    int          lat;
    bit          exp_miss;
    logic [31:0] exp_inst;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_flush();
    for (int s = 0; s < 128; s++) rec[s].delete();
  endtask

  task automatic model_access(input logic [15:0] w, output bit hit);
    int s;
    int idx;
    s   = int'(w[6:0]);
    idx = -1;
    for (int i = 0; i < rec[s].size(); i++) if (rec[s][i] == w) idx = i;
    hit = (idx >= 0);
    if (hit) rec[s].delete(idx);
    else if (rec[s].size() == WAYS) void'(rec[s].pop_front());
    rec[s].push_back(w);
  endtask

  // Drive one fetch until the instruction pulse, serving any refill after lat cycles.
  task automatic do_fetch(input logic [17:0] addr, input logic [31:0] word, input int lat,
                          input int mem_hold, input bit flush_first,
                          output bit got, output logic [31:0] inst,
                          output bit saw, output logic [31:0] saw_addr);
    int cnt;
    got = 1'b0; saw = 1'b0; inst = '0; saw_addr = '0; cnt = 0;
    IF_in = 1'b1; IFAddr_in = addr; flush_in = flush_first;
    for (int c = 0; c < 200 && !got; c++) begin
      MEM_MCAccess_in = (c < mem_hold) && c[0];
      MC_busyMEM_in   = (c < mem_hold) && !c[0];
      step();
      flush_in = 1'b0; MCinstE_in = 1'b0; MCinst_in = '0;
      if (IF_instE_out) begin
        got  = 1'b1;
        inst = IF_inst_out;
      end else if (MCE_out) begin
        if (!saw) begin saw = 1'b1; saw_addr = MC_addr_out; cnt = lat; end
        if (cnt == 0) begin MCinstE_in = 1'b1; MCinst_in = word; end
        cnt--;
      end
    end
    IF_in = 1'b0; MEM_MCAccess_in = 1'b0; MC_busyMEM_in = 1'b0;
    check("fetch_done", 32'(got), 32'd1);
    step();
    check("pulse_end", 32'(IF_instE_out), 32'd0);
  endtask

  bit          got, saw, hit, fl;
  logic [31:0] inst, saddr, w;
  logic [17:0] a;
  int          sv, tv;

  initial begin
    vecs[0] = '{18'h00100, 32'hDEADBEEF, 3, 1'b1, 32'hDEADBEEF, 16'd1};
    vecs[1] = '{18'h00100, 32'h00000000, 0, 1'b0, 32'hDEADBEEF, 16'd1};
    vecs[2] = '{18'h00300, 32'h11112222, 0, 1'b1, 32'h11112222, 16'd2};
    vecs[3] = '{18'h00500, 32'h33334444, 2, 1'b1, 32'h33334444, 16'd3};
    vecs[4] = '{18'h00300, 32'h00000000, 0, 1'b0, 32'h11112222, 16'd3};
    vecs[5] = '{18'h00100, 32'hCAFEF00D, 1, 1'b1, 32'hCAFEF00D, 16'd4};
    vecs[6] = '{18'h00500, 32'h55556666, 4, 1'b1, 32'h55556666, 16'd5};
    vecs[7] = '{18'h00100, 32'h00000000, 0, 1'b0, 32'hCAFEF00D, 16'd5};
    vecs[8] = '{18'h00102, 32'h00000000, 0, 1'b0, 32'hCAFEF00D, 16'd5};

    rst_in = 1'b0; rdy_in = 1'b1; IF_in = 1'b0; IFAddr_in = '0; flush_in = 1'b0;
    MEM_MCAccess_in = 1'b0; MC_busyMEM_in = 1'b0; MCinstE_in = 1'b0; MCinst_in = '0;
    step(); step();
    rst_in = 1'b1;
    check("rst_inst_e", 32'(IF_instE_out), 32'd0);
    check("rst_inst", IF_inst_out, 32'd0);
    check("rst_mce", 32'(MCE_out), 32'd0);
    check("rst_mc_addr", MC_addr_out, 32'd0);
    check("rst_cnt", 32'(miss_cnt_out), 32'd0);

    // Vector table: cold miss, hit, same-set fills and LRU eviction.
    for (int i = 0; i < 9; i++) begin
      do_fetch(vecs[i].addr, vecs[i].word, vecs[i].lat, 0, 1'b0, got, inst, saw, saddr);
      check($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_miss", i), 32'(saw), 32'(vecs[i].exp_miss));
      if (vecs[i].exp_miss)
        check($sformatf("vec%0d_mcaddr", i), saddr, {14'b0, vecs[i].addr[17:2], 2'b00});
      check($sformatf("vec%0d_cnt", i), 32'(miss_cnt_out), 32'(vecs[i].exp_cnt));
    end

    // Stall holds the hit pulse, and freezes WAIT against a refill pulse.
    IF_in = 1'b1; IFAddr_in = 18'h00100; step();
    check("stall_hit_pulse", 32'(IF_instE_out), 32'd1);
    rdy_in = 1'b0; IF_in = 1'b0; step();
    check("stall_hold_e", 32'(IF_instE_out), 32'd1);
    check("stall_hold_inst", IF_inst_out, 32'hCAFEF00D);
    rdy_in = 1'b1; step();
    check("stall_release", 32'(IF_instE_out), 32'd0);
    IF_in = 1'b1; IFAddr_in = 18'h00B00; step(); step();
    check("stall_wait_mce", 32'(MCE_out), 32'd1);
    rdy_in = 1'b0; MCinstE_in = 1'b1; MCinst_in = 32'h0BAD0BAD; step();
    check("stall_wait_noresp", 32'(IF_instE_out), 32'd0);
    check("stall_wait_mce_held", 32'(MCE_out), 32'd1);
    rdy_in = 1'b1; MCinstE_in = 1'b0; step();
    check("stall_wait_mce2", 32'(MCE_out), 32'd1);
    check("stall_wait_noresp2", 32'(IF_instE_out), 32'd0);
    MCinstE_in = 1'b1; MCinst_in = 32'h0B0B0B0B; step(); MCinstE_in = 1'b0;
    check("stall_refill_e", 32'(IF_instE_out), 32'd1);
    check("stall_refill_inst", IF_inst_out, 32'h0B0B0B0B);
    IF_in = 1'b0; step();
    exp_cnt = 16'd6;
    check("stall_cnt", 32'(miss_cnt_out), 32'(exp_cnt));

    // MEM-stage priority holds the refill request for four cycles.
    IF_in = 1'b1; IFAddr_in = 18'h00700; MEM_MCAccess_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mem_prio_mce", 32'(MCE_out), 32'd0);
      check("mem_prio_addr", MC_addr_out, 32'd0);
    end
    MEM_MCAccess_in = 1'b0; step();
    check("release_mce", 32'(MCE_out), 32'd1);
    check("release_addr", MC_addr_out, 32'h00000700);
    MCinstE_in = 1'b1; MCinst_in = 32'h77777777; step(); MCinstE_in = 1'b0;
    check("release_e", 32'(IF_instE_out), 32'd1);
    check("release_inst", IF_inst_out, 32'h77777777);
    IF_in = 1'b0; step();
    exp_cnt = 16'd7;
    check("release_cnt", 32'(miss_cnt_out), 32'(exp_cnt));

    // Abort while in REQ, then a stray refill pulse in IDLE.
    IF_in = 1'b1; IFAddr_in = 18'h00D00; MEM_MCAccess_in = 1'b1; step();
    IF_in = 1'b0; step();
    MEM_MCAccess_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_mce", 32'(MCE_out), 32'd0);
    end
    exp_cnt = 16'd8;
    check("abort_cnt", 32'(miss_cnt_out), 32'(exp_cnt));
    MCinstE_in = 1'b1; MCinst_in = 32'h12345678; step(); MCinstE_in = 1'b0;
    check("stray_e", 32'(IF_instE_out), 32'd0);
    step();
    check("stray_e2", 32'(IF_instE_out), 32'd0);
    do_fetch(18'h00D00, 32'hD0D0D0D0, 1, 0, 1'b0, got, inst, saw, saddr);
    exp_cnt = 16'd9;
    check("abort_refetch_miss", 32'(saw), 32'd1);
    check("abort_refetch_inst", inst, 32'hD0D0D0D0);
    check("abort_refetch_cnt", 32'(miss_cnt_out), 32'(exp_cnt));

    // Fetch dropped during WAIT: refill installed silently.
    IF_in = 1'b1; IFAddr_in = 18'h00F04; step(); step();
    check("drop_mce", 32'(MCE_out), 32'd1);
    IF_in = 1'b0; step();
    check("drop_mce_held", 32'(MCE_out), 32'd1);
    MCinstE_in = 1'b1; MCinst_in = 32'hF00DF00D; step(); MCinstE_in = 1'b0;
    check("drop_no_pulse", 32'(IF_instE_out), 32'd0);
    check("drop_mce_off", 32'(MCE_out), 32'd0);
    check("drop_addr_off", MC_addr_out, 32'd0);
    exp_cnt = 16'd10;
    do_fetch(18'h00F04, 32'hDEAD0000, 0, 0, 1'b0, got, inst, saw, saddr);
    check("drop_refetch_hit", 32'(saw), 32'd0);
    check("drop_refetch_inst", inst, 32'hF00DF00D);
    check("drop_refetch_cnt", 32'(miss_cnt_out), 32'(exp_cnt));

    // Flush during WAIT: word returned but not kept; whole cache invalidated.
    IF_in = 1'b1; IFAddr_in = 18'h00900; step(); step();
    check("flush_mce", 32'(MCE_out), 32'd1);
    flush_in = 1'b1; step(); flush_in = 1'b0;
    check("flush_mce_held", 32'(MCE_out), 32'd1);
    MCinstE_in = 1'b1; MCinst_in = 32'h99990000; step(); MCinstE_in = 1'b0;
    check("flush_e", 32'(IF_instE_out), 32'd1);
    check("flush_inst", IF_inst_out, 32'h99990000);
    IF_in = 1'b0; step();
    do_fetch(18'h00900, 32'h99991111, 1, 0, 1'b0, got, inst, saw, saddr);
    exp_cnt = 16'd12;
    check("flush_refetch_miss", 32'(saw), 32'd1);
    check("flush_refetch_inst", inst, 32'h99991111);
    check("flush_refetch_cnt", 32'(miss_cnt_out), 32'(exp_cnt));
    do_fetch(18'h00F04, 32'hF0F0F0F0, 0, 0, 1'b0, got, inst, saw, saddr);
    check("flush_other_miss", 32'(saw), 32'd1);
    check("flush_other_inst", inst, 32'hF0F0F0F0);

    // Reset in WAIT (while stalled): pending refill dropped, cache cleared.
    IF_in = 1'b1; IFAddr_in = 18'h01104; step(); step();
    check("rstw_mce", 32'(MCE_out), 32'd1);
    rst_in = 1'b0; rdy_in = 1'b0; step();
    rst_in = 1'b1; rdy_in = 1'b1; IF_in = 1'b0;
    check("rstw_e", 32'(IF_instE_out), 32'd0);
    check("rstw_mce_off", 32'(MCE_out), 32'd0);
    check("rstw_addr", MC_addr_out, 32'd0);
    check("rstw_cnt", 32'(miss_cnt_out), 32'd0);
    MCinstE_in = 1'b1; MCinst_in = 32'h11041104; step(); MCinstE_in = 1'b0;
    check("rstw_late_e", 32'(IF_instE_out), 32'd0);
    check("rstw_late_inst", IF_inst_out, 32'd0);
    do_fetch(18'h01104, 32'h5555AAAA, 2, 0, 1'b0, got, inst, saw, saddr);
    check("rstw_refetch_miss", 32'(saw), 32'd1);
    check("rstw_refetch_inst", inst, 32'h5555AAAA);
    check("rstw_refetch_cnt", 32'(miss_cnt_out), 32'd1);
    do_fetch(18'h00900, 32'h90909090, 0, 0, 1'b0, got, inst, saw, saddr);
    check("rstw_cleared_miss", 32'(saw), 32'd1);

    // Random fetch stream against the recency-list model.
    rst_in = 1'b0; step(); rst_in = 1'b1;
    model_flush();
    mdata.delete();
    exp_cnt = 16'd0;
    for (int n = 0; n < 200; n++) begin
      tv = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       sv = 0;
        1:       sv = 1;
        2:       sv = 64;
        default: sv = 127;
      endcase
      a  = 18'((tv << 9) | (sv << 2) | int'($urandom_range(0, 3)));
      fl = ($urandom_range(0, 15) == 0);
      if (fl) model_flush();
      model_access(a[17:2], hit);
      w = $urandom();
      if (!hit) begin
        mdata[a[17:2]] = w;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        exp_q.push_back(w);
      end else begin
        exp_q.push_back(mdata[a[17:2]]);
      end
      do_fetch(a, w, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), fl,
               got, inst, saw, saddr);
      check("rnd_inst", inst, exp_q.pop_front());
      check("rnd_miss", 32'(saw), 32'(!hit));
      if (!hit) check("rnd_mcaddr", saddr, {14'b0, a[17:2], 2'b00});
      check("rnd_cnt", 32'(miss_cnt_out), 32'(exp_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
